// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : RV32I shared decode types, opcode constants and operand-use helpers
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   typedef enum logic [3:0] {
      OP_NOP     = 4'd0,
      OP_LUI     = 4'd1,
      OP_AUIPC   = 4'd2,
      OP_JAL     = 4'd3,
      OP_JALR    = 4'd4,
      OP_BRANCH  = 4'd5,
      OP_LOAD    = 4'd6,
      OP_STORE   = 4'd7,
      OP_ALUI    = 4'd8,
      OP_ALU     = 4'd9,
      OP_FENCE   = 4'd10,
      OP_SYSTEM  = 4'd11,
      OP_ILLEGAL = 4'd12
   } op_e;

   typedef enum logic [2:0] {
      IMM_R = 3'd0,
      IMM_I = 3'd1,
      IMM_S = 3'd2,
      IMM_B = 3'd3,
      IMM_U = 3'd4,
      IMM_J = 3'd5
   } imm_fmt_e;

   localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] C_OPC_OP     = 7'b0110011;
   localparam logic [6:0] C_OPC_MISC   = 7'b0001111;
   localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] C_BOOT_NOP = 32'h0000_0013;

   function automatic logic rs1_used(input op_e op);
      return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
   endfunction

   function automatic logic rs2_used(input op_e op);
      return op inside {OP_BRANCH, OP_STORE, OP_ALU};
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : riscv_imm_gen
// Brief    : RV32I immediate extraction and sign extension by instruction format
// Revision : 1.0 - initial release
// ============================================================================
module riscv_imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0] i_instr,
   input  imm_fmt_e    i_fmt,
   output logic [31:0] o_imm
);

   logic w_unused_opc;
   assign w_unused_opc = ^i_instr[6:0];

   always_comb begin
      o_imm = 32'd0;
      case (i_fmt)
         IMM_I:   o_imm = {{21{i_instr[31]}}, i_instr[30:20]};
         IMM_S:   o_imm = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
         IMM_B:   o_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   o_imm = {i_instr[31:12], 12'd0};
         IMM_J:   o_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         default: o_imm = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/riscv_id.sv
`default_nettype none
// ============================================================================
// Module   : riscv_id
// Brief    : RV32I decode stage with early JAL redirect, load-use interlock
//            and ID/EX pipeline register
// Revision : 1.0 - initial release
// ============================================================================
module riscv_id
   import riscv_pkg::*;
#(
   parameter logic [31:0] BOOT_NOP = C_BOOT_NOP
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   input  logic        i_ex_jmp,
   input  logic        i_stall,
   output logic        o_stall,
   output logic        o_id_jmp,
   output logic [31:0] o_id_target,
   output logic [4:0]  o_rs1_addr,
   output logic [4:0]  o_rs2_addr,
   output logic        o_ex_valid,
   output logic [31:0] o_ex_pc,
   output logic [31:0] o_ex_instr,
   output op_e         o_ex_op,
   output logic [4:0]  o_ex_rd,
   output logic [4:0]  o_ex_rs1,
   output logic [4:0]  o_ex_rs2,
   output logic [2:0]  o_ex_funct3,
   output logic        o_ex_funct7b5,
   output logic [31:0] o_ex_imm,
   output logic        o_ex_illegal
);

   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   op_e         w_op;
   imm_fmt_e    w_fmt;
   logic        w_illegal;
   logic [31:0] w_imm;
   logic [31:0] w_jimm;
   logic        w_in_valid;
   logic        w_load_use;

   logic        r_kill;
   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   op_e         r_op;
   logic [4:0]  r_rd;
   logic [4:0]  r_rs1;
   logic [4:0]  r_rs2;
   logic [2:0]  r_funct3;
   logic        r_funct7b5;
   logic [31:0] r_imm;
   logic        r_illegal;

   assign w_opcode = i_instr[6:0];
   assign w_rd     = i_instr[11:7];
   assign w_rs1    = i_instr[19:15];
   assign w_rs2    = i_instr[24:20];

   always_comb begin
      w_op      = OP_ILLEGAL;
      w_fmt     = IMM_R;
      w_illegal = 1'b1;
      if (i_instr[1:0] == 2'b11) begin
         w_illegal = 1'b0;
         case (w_opcode)
            C_OPC_LUI:    begin w_op = OP_LUI;    w_fmt = IMM_U; end
            C_OPC_AUIPC:  begin w_op = OP_AUIPC;  w_fmt = IMM_U; end
            C_OPC_JAL:    begin w_op = OP_JAL;    w_fmt = IMM_J; end
            C_OPC_JALR:   begin w_op = OP_JALR;   w_fmt = IMM_I; end
            C_OPC_BRANCH: begin w_op = OP_BRANCH; w_fmt = IMM_B; end
            C_OPC_LOAD:   begin w_op = OP_LOAD;   w_fmt = IMM_I; end
            C_OPC_STORE:  begin w_op = OP_STORE;  w_fmt = IMM_S; end
            C_OPC_OPIMM:  begin w_op = OP_ALUI;   w_fmt = IMM_I; end
            C_OPC_OP:     begin w_op = OP_ALU;    w_fmt = IMM_R; end
            C_OPC_MISC:   begin w_op = OP_FENCE;  w_fmt = IMM_I; end
            C_OPC_SYSTEM: begin w_op = OP_SYSTEM; w_fmt = IMM_I; end
            default: begin
               w_op      = OP_ILLEGAL;
               w_illegal = 1'b1;
            end
         endcase
      end
   end

   riscv_imm_gen u_imm_gen (
      .i_instr (i_instr),
      .i_fmt   (w_fmt),
      .o_imm   (w_imm)
   );

   // The JAL target needs the J immediate regardless of what the format mux picked.
   riscv_imm_gen u_jimm_gen (
      .i_instr (i_instr),
      .i_fmt   (IMM_J),
      .o_imm   (w_jimm)
   );

   assign w_in_valid = (i_instr != 32'd0) && !r_kill;

   assign w_load_use = r_valid && (r_op == OP_LOAD) && (r_rd != 5'd0) && w_in_valid &&
                       ((rs1_used(w_op) && (w_rs1 == r_rd)) ||
                        (rs2_used(w_op) && (w_rs2 == r_rd)));

   assign o_stall     = w_load_use || i_stall;
   assign o_id_jmp    = w_in_valid && (w_op == OP_JAL) && !i_ex_jmp && !o_stall;
   assign o_id_target = i_pc + w_jimm;
   assign o_rs1_addr  = w_rs1;
   assign o_rs2_addr  = w_rs2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_kill     <= 1'b0;
         r_valid    <= 1'b0;
         r_pc       <= 32'd0;
         r_instr    <= BOOT_NOP;
         r_op       <= OP_NOP;
         r_rd       <= 5'd0;
         r_rs1      <= 5'd0;
         r_rs2      <= 5'd0;
         r_funct3   <= 3'd0;
         r_funct7b5 <= 1'b0;
         r_imm      <= 32'd0;
         r_illegal  <= 1'b0;
      end else if (i_ex_jmp) begin
         r_kill    <= 1'b0;
         r_valid   <= 1'b0;
         r_op      <= OP_NOP;
         r_instr   <= BOOT_NOP;
         r_illegal <= 1'b0;
      end else if (i_stall) begin
         r_kill <= r_kill;
      end else if (w_load_use) begin
         r_valid   <= 1'b0;
         r_op      <= OP_NOP;
         r_instr   <= BOOT_NOP;
         r_illegal <= 1'b0;
      end else begin
         // A taken JAL poisons exactly the next word, which is the wrong-path fetch.
         r_kill     <= o_id_jmp;
         r_valid    <= w_in_valid;
         r_pc       <= i_pc;
         r_rd       <= w_rd;
         r_rs1      <= w_rs1;
         r_rs2      <= w_rs2;
         r_funct3   <= i_instr[14:12];
         r_funct7b5 <= i_instr[30];
         r_imm      <= w_imm;
         if (w_in_valid) begin
            r_instr   <= i_instr;
            r_op      <= w_op;
            r_illegal <= w_illegal;
         end else begin
            r_instr   <= BOOT_NOP;
            r_op      <= OP_NOP;
            r_illegal <= 1'b0;
         end
      end
   end

   assign o_ex_valid    = r_valid;
   assign o_ex_pc       = r_pc;
   assign o_ex_instr    = r_instr;
   assign o_ex_op       = r_op;
   assign o_ex_rd       = r_rd;
   assign o_ex_rs1      = r_rs1;
   assign o_ex_rs2      = r_rs2;
   assign o_ex_funct3   = r_funct3;
   assign o_ex_funct7b5 = r_funct7b5;
   assign o_ex_imm      = r_imm;
   assign o_ex_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_riscv_id.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_id
// Brief    : directed self-checking bench for the riscv_id decode stage
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_id;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] i_pc;
   logic [31:0] i_instr;
   logic        i_ex_jmp;
   logic        i_stall;
   logic        o_stall;
   logic        o_id_jmp;
   logic [31:0] o_id_target;
   logic [4:0]  o_rs1_addr;
   logic [4:0]  o_rs2_addr;
   logic        o_ex_valid;
   logic [31:0] o_ex_pc;
   logic [31:0] o_ex_instr;
   op_e         o_ex_op;
   logic [4:0]  o_ex_rd;
   logic [4:0]  o_ex_rs1;
   logic [4:0]  o_ex_rs2;
   logic [2:0]  o_ex_funct3;
   logic        o_ex_funct7b5;
   logic [31:0] o_ex_imm;
   logic        o_ex_illegal;

   int n_checks;
   int n_fail;

   riscv_id u_dut (
      .clk           (clk),
      .rst           (rst),
      .i_pc          (i_pc),
      .i_instr       (i_instr),
      .i_ex_jmp      (i_ex_jmp),
      .i_stall       (i_stall),
      .o_stall       (o_stall),
      .o_id_jmp      (o_id_jmp),
      .o_id_target   (o_id_target),
      .o_rs1_addr    (o_rs1_addr),
      .o_rs2_addr    (o_rs2_addr),
      .o_ex_valid    (o_ex_valid),
      .o_ex_pc       (o_ex_pc),
      .o_ex_instr    (o_ex_instr),
      .o_ex_op       (o_ex_op),
      .o_ex_rd       (o_ex_rd),
      .o_ex_rs1      (o_ex_rs1),
      .o_ex_rs2      (o_ex_rs2),
      .o_ex_funct3   (o_ex_funct3),
      .o_ex_funct7b5 (o_ex_funct7b5),
      .o_ex_imm      (o_ex_imm),
      .o_ex_illegal  (o_ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                        input logic jmp, input logic stall);
      i_pc     = pc;
      i_instr  = instr;
      i_ex_jmp = jmp;
      i_stall  = stall;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      i_pc     = 32'd0;
      i_instr  = 32'd0;
      i_ex_jmp = 1'b0;
      i_stall  = 1'b0;
      #2;
      check_val("rst_valid", 32'(o_ex_valid), 32'd0);
      check_val("rst_op",    32'(o_ex_op),    32'(OP_NOP));
      check_val("rst_instr", o_ex_instr,      32'h0000_0013);
      check_val("rst_pc",    o_ex_pc,         32'd0);
      check_val("rst_stall", 32'(o_stall),    32'd0);
      tick();
      rst = 1'b0;

      // addi x1,x0,5
      drive(32'h100, 32'h0050_0093, 1'b0, 1'b0);
      check_val("addi_rs1_addr", 32'(o_rs1_addr), 32'd0);
      check_val("addi_nojmp",    32'(o_id_jmp),   32'd0);
      tick();
      check_val("addi_valid",   32'(o_ex_valid),   32'd1);
      check_val("addi_op",      32'(o_ex_op),      32'(OP_ALUI));
      check_val("addi_rd",      32'(o_ex_rd),      32'd1);
      check_val("addi_rs1",     32'(o_ex_rs1),     32'd0);
      check_val("addi_imm",     o_ex_imm,          32'd5);
      check_val("addi_pc",      o_ex_pc,           32'h100);
      check_val("addi_illegal", 32'(o_ex_illegal), 32'd0);

      // jal x1,+8 then a wrong-path JAL that must be squashed
      drive(32'h200, 32'h0080_00EF, 1'b0, 1'b0);
      check_val("jal_jmp",    32'(o_id_jmp), 32'd1);
      check_val("jal_target", o_id_target,   32'h208);
      tick();
      check_val("jal_ex_valid", 32'(o_ex_valid), 32'd1);
      check_val("jal_ex_op",    32'(o_ex_op),    32'(OP_JAL));
      check_val("jal_ex_rd",    32'(o_ex_rd),    32'd1);
      check_val("jal_ex_imm",   o_ex_imm,        32'd8);
      drive(32'h204, 32'h0080_00EF, 1'b0, 1'b0);
      check_val("kill_nojmp", 32'(o_id_jmp), 32'd0);
      tick();
      check_val("kill_valid", 32'(o_ex_valid), 32'd0);
      check_val("kill_op",    32'(o_ex_op),    32'(OP_NOP));
      drive(32'h208, 32'h0050_0093, 1'b0, 1'b0);
      tick();
      check_val("after_kill_valid", 32'(o_ex_valid), 32'd1);
      check_val("after_kill_pc",    o_ex_pc,         32'h208);

      // jal x0,-4 at pc 0 wraps
      drive(32'h0, 32'hFFDF_F06F, 1'b0, 1'b0);
      check_val("wrap_jmp",    32'(o_id_jmp), 32'd1);
      check_val("wrap_target", o_id_target,   32'hFFFF_FFFC);
      tick();
      check_val("wrap_ex_imm", o_ex_imm, 32'hFFFF_FFFC);
      drive(32'h4, 32'h0, 1'b0, 1'b0);
      tick();

      // sw x2,8(x1)
      drive(32'h280, 32'h0020_A423, 1'b0, 1'b0);
      tick();
      check_val("sw_op",  32'(o_ex_op), 32'(OP_STORE));
      check_val("sw_imm", o_ex_imm,     32'd8);

      // lw x2,0(x1) ; add x3,x2,x2
      drive(32'h300, 32'h0000_A103, 1'b0, 1'b0);
      check_val("lw_nostall", 32'(o_stall), 32'd0);
      tick();
      check_val("lw_op", 32'(o_ex_op), 32'(OP_LOAD));
      drive(32'h304, 32'h0021_01B3, 1'b0, 1'b0);
      check_val("lu_stall", 32'(o_stall), 32'd1);
      tick();
      check_val("lu_bubble_valid", 32'(o_ex_valid), 32'd0);
      check_val("lu_bubble_op",    32'(o_ex_op),    32'(OP_NOP));
      check_val("lu_stall_drop",   32'(o_stall),    32'd0);
      tick();
      check_val("lu_add_valid", 32'(o_ex_valid), 32'd1);
      check_val("lu_add_op",    32'(o_ex_op),    32'(OP_ALU));
      check_val("lu_add_rs1",   32'(o_ex_rs1),   32'd2);
      check_val("lu_add_rs2",   32'(o_ex_rs2),   32'd2);
      check_val("lu_add_rd",    32'(o_ex_rd),    32'd3);

      // lw x0 ; add x3,x0,x0 -> no interlock
      drive(32'h320, 32'h0000_A003, 1'b0, 1'b0);
      tick();
      drive(32'h324, 32'h0000_01B3, 1'b0, 1'b0);
      check_val("x0_nostall", 32'(o_stall), 32'd0);
      tick();
      check_val("x0_valid", 32'(o_ex_valid), 32'd1);
      check_val("x0_pc",    o_ex_pc,         32'h324);

      // i_stall holds the ID/EX register
      drive(32'h500, 32'h0050_0093, 1'b0, 1'b0);
      tick();
      drive(32'h504, 32'h0000_A103, 1'b0, 1'b1);
      check_val("hold_stall", 32'(o_stall), 32'd1);
      tick();
      check_val("hold_pc",    o_ex_pc,         32'h500);
      check_val("hold_op",    32'(o_ex_op),    32'(OP_ALUI));

      // flush wins over stall
      drive(32'h400, 32'h0050_0093, 1'b1, 1'b1);
      check_val("flush_stall", 32'(o_stall),  32'd1);
      check_val("flush_nojmp", 32'(o_id_jmp), 32'd0);
      tick();
      check_val("flush_valid", 32'(o_ex_valid), 32'd0);
      drive(32'h410, 32'h0080_00EF, 1'b1, 1'b1);
      check_val("flush_jal_nojmp", 32'(o_id_jmp), 32'd0);
      tick();
      drive(32'h414, 32'h0050_0093, 1'b0, 1'b0);
      tick();
      check_val("flush_nokill_valid", 32'(o_ex_valid), 32'd1);
      check_val("flush_nokill_pc",    o_ex_pc,         32'h414);

      // illegal and bubble words
      drive(32'h600, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tick();
      check_val("ill_valid",   32'(o_ex_valid),   32'd1);
      check_val("ill_illegal", 32'(o_ex_illegal), 32'd1);
      check_val("ill_op",      32'(o_ex_op),      32'(OP_ILLEGAL));
      drive(32'h604, 32'h0, 1'b0, 1'b0);
      tick();
      check_val("bubble_valid", 32'(o_ex_valid), 32'd0);
      check_val("bubble_instr", o_ex_instr,      32'h0000_0013);

      // asynchronous reset mid-stream
      drive(32'h700, 32'h0050_0093, 1'b0, 1'b0);
      tick();
      check_val("pre_rst_valid", 32'(o_ex_valid), 32'd1);
      rst = 1'b1;
      #1;
      check_val("async_rst_valid", 32'(o_ex_valid), 32'd0);
      check_val("async_rst_instr", o_ex_instr,      32'h0000_0013);
      tick();
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/riscv_id.md
Name: riscv_id

Overview:
RV32I decode stage, directly downstream of instruction fetch. Consumes the fetched pc/instr pair, decodes it and generates the immediate, and resolves JAL early by driving the fetch stage's id-jump redirect. Detects load-use hazards against the instruction in EX, and registers the decoded bundle into the ID/EX pipeline register. Branches and JALR resolve in EX; EX redirects flush this stage.

Parameters:
- BOOT_NOP, 32'h0000_0013 (addi x0,x0,0): instruction word loaded into the ID/EX pipeline register at reset and on bubbles.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_pc  in  32  pc of i_instr, from fetch
- i_instr  in  32  fetched word; 32'h0 is a fetch bubble
- i_ex_jmp  in  1  EX redirect; flush
- i_stall  in  1  downstream hold
- o_stall  out  1  hold request to fetch
- o_id_jmp  out  1  JAL taken, to fetch
- o_id_target  out  32  JAL target, to fetch
- o_rs1_addr, o_rs2_addr  out  5 each  regfile read addresses (combinational)
- o_ex_valid  out  1  EX bundle valid
- o_ex_pc  out  32
- o_ex_instr  out  32
- o_ex_op  out  op_e  decoded class
- o_ex_rd, o_ex_rs1, o_ex_rs2  out  5 each
- o_ex_funct3  out  3
- o_ex_funct7b5  out  1  instr[30]
- o_ex_imm  out  32  sign-extended immediate
- o_ex_illegal  out  1

Behaviour:
- Reset (asynchronous, rst=1): o_ex_valid=0, o_ex_op=OP_NOP, o_ex_instr=BOOT_NOP, all other o_ex_* = 0, kill_q=0. Combinational outputs follow from these values. Deassertion takes effect at the next clk edge.
- in_valid = (i_instr != 0) & ~kill_q.
- Decode is combinational on i_instr:
  - opcode map: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM→OP_ALUI, OP→OP_ALU, MISC-MEM→OP_FENCE, SYSTEM.
  - Any other opcode, or instr[1:0] != 2'b11, gives OP_ILLEGAL with illegal=1.
- Immediate by format: I/S/B/U/J, sign bit instr[31]. R-type gives 0.
- rs-use: rs1 used by all ops except LUI/AUIPC/JAL. rs2 used by BRANCH/STORE/ALU.
- load_use = o_ex_valid & (o_ex_op==OP_LOAD) & (o_ex_rd!=0) & in_valid & ((rs1 used & rs1==o_ex_rd) | (rs2 used & rs2==o_ex_rd)).
- o_stall = load_use | i_stall.
- o_id_jmp = in_valid & op==OP_JAL & ~i_ex_jmp & ~o_stall. Same cycle as the JAL sits at ID input.
- o_id_target = i_pc + J-imm, modulo 2^32 (wraps, no overflow flag). Target bits [1:0] are passed unchanged; misalignment is EX's concern.
- Per-edge priority for the ID/EX register:
  1. i_ex_jmp: valid<=0, op<=OP_NOP, kill_q<=0.
  2. i_stall: hold all ID/EX registers and kill_q.
  3. load_use: insert bubble (valid<=0, op<=OP_NOP); kill_q unchanged.
  4. Otherwise: load the decoded bundle with valid<=in_valid. A squashed or bubble word loads as valid=0, OP_NOP.
- kill_q <= o_id_jmp when not flushed or held. It squashes exactly one following word, the wrong-path fetch.
- A JAL itself proceeds to EX valid (EX writes rd=pc+4).
- Simultaneous i_ex_jmp with load_use or i_stall: flush wins, and o_stall is still driven combinationally.
- Latency: 1 cycle from ID input to o_ex_*. o_id_jmp has 0 cycles of latency.

Decomposition:
- riscv_pkg: op_e enum (OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ALUI, OP_ALU, OP_FENCE, OP_SYSTEM, OP_ILLEGAL), the 7-bit opcode localparams, and the BOOT_NOP constant. EX shares this package.
- Sub-module riscv_imm_gen: purely combinational, takes instr[31:0] and a format select, returns imm[31:0].

Test Plan:
- Decode: addi x1,x0,5 (32'h00500093) at pc 0x100 → next edge: valid=1, op=OP_ALUI, rd=1, rs1=0, imm=5, pc=0x100, illegal=0.
- JAL forward: jal x1,+8 (32'h008000EF) at pc 0x200 → same cycle o_id_jmp=1, target=0x208. Next edge: JAL valid in EX with rd=1. The following word (pc 0x204) is loaded with valid=0.
- JAL wrap: jal x0,-4 (32'hFFDFF06F) at pc 0x0 → target 0xFFFFFFFC.
- Load-use: lw x2,0(x1) (32'h0000A103) then add x3,x2,x2 (32'h002101B3) → o_stall=1 for exactly 1 cycle and one valid=0 bubble, then add valid with rs1=rs2=2. Changing rd to x0 gives no stall.
- Flush priority: valid addi with i_stall=1 and i_ex_jmp=1 → next edge valid=0 and o_id_jmp=0. Same setup with JAL in place of addi → kill_q stays 0.
- Illegal/bubble: i_instr=32'hFFFFFFFF → valid=1, illegal=1, op=OP_ILLEGAL. i_instr=0 → valid=0. Assert rst mid-stream → o_ex_valid drops to 0 immediately, with no clk edge.
